// File: rtl/microwatt_mp_regfile.sv
// Multi-port register file with write bypass, highest-port-wins write priority and a
// post-reset / on-request clear sequencer. Define MP_REGFILE_PARITY_EN for per-entry parity.
module microwatt_mp_regfile #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 96,
  parameter int AW     = 7,
  parameter int NREAD  = 3,
  parameter int NWRITE = 2,
  parameter int BYPASS = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [NREAD*AW-1:0]     R,
  output logic [NREAD*WIDTH-1:0]  D,
  input  logic [NWRITE*AW-1:0]    RW,
  input  logic [NWRITE*WIDTH-1:0] DW,
  input  logic [NWRITE-1:0]       WE,
  input  logic                    CLR,
`ifdef MP_REGFILE_PARITY_EN
  input  logic [NWRITE-1:0]       PINJ,
  output logic [NREAD-1:0]        PERR,
`endif
  output logic                    READY
);

  typedef enum logic [0:0] {ST_CLEARING = 1'b0, ST_IDLE = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              ready_s;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     rd_addr_s [NREAD];
  logic [AW-1:0]     wr_addr_s [NWRITE];
  logic [WIDTH-1:0]  wr_data_s [NWRITE];
  logic [NWRITE-1:0] wen_s;
  logic [NREAD-1:0]  byp_hit_s;
`ifdef MP_REGFILE_PARITY_EN
  logic              par_q [DEPTH];
`endif

  function automatic logic even_par(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Widened compare so DEPTH == 2**AW still works.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return {1'b0, a} < (AW+1)'(DEPTH);
  endfunction

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_CLEARING;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEARING: begin
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (CLR) begin
          state_d = ST_CLEARING;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_CLEARING;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    ready_s = (state_q == ST_IDLE);
  end

  assign READY = ready_s;

  // Port unpacking and effective write enables
  always_comb begin
    for (int i = 0; i < NREAD; i++) rd_addr_s[i] = R[i*AW +: AW];
    for (int j = 0; j < NWRITE; j++) begin
      wr_addr_s[j] = RW[j*AW +: AW];
      wr_data_s[j] = DW[j*WIDTH +: WIDTH];
      wen_s[j]     = WE[j] & ready_s & addr_ok(RW[j*AW +: AW]);
    end
  end

  // Array storage: ascending port loop lets the highest enabled port win a shared address
  always_ff @(posedge CLK) begin
    if (state_q == ST_CLEARING) begin
      mem_q[cnt_q] <= '0;
`ifdef MP_REGFILE_PARITY_EN
      par_q[cnt_q] <= 1'b0;
`endif
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wen_s[j]) begin
          mem_q[wr_addr_s[j]] <= wr_data_s[j];
`ifdef MP_REGFILE_PARITY_EN
          par_q[wr_addr_s[j]] <= even_par(wr_data_s[j]) ^ PINJ[j];
`endif
        end
      end
    end
  end

  // Combinational read with optional same-cycle bypass
  always_comb begin
    D         = '0;
    byp_hit_s = '0;
`ifdef MP_REGFILE_PARITY_EN
    PERR      = '0;
`endif
    for (int i = 0; i < NREAD; i++) begin
      if (ready_s && addr_ok(rd_addr_s[i])) begin
        D[i*WIDTH +: WIDTH] = mem_q[rd_addr_s[i]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWRITE; j++) begin
            byp_hit_s[i] = byp_hit_s[i] | (wen_s[j] & (wr_addr_s[j] == rd_addr_s[i]));
            D[i*WIDTH +: WIDTH] = (wen_s[j] && (wr_addr_s[j] == rd_addr_s[i])) ?
                                  wr_data_s[j] : D[i*WIDTH +: WIDTH];
          end
        end else begin
          byp_hit_s[i] = 1'b0;
        end
`ifdef MP_REGFILE_PARITY_EN
        PERR[i] = ~byp_hit_s[i] & (even_par(mem_q[rd_addr_s[i]]) ^ par_q[rd_addr_s[i]]);
`endif
      end else begin
        D[i*WIDTH +: WIDTH] = '0;
      end
    end
  end

endmodule
